// File: rtl/game_match_tracker.sv
// Match scorekeeper: counts games and points per side across a best-of match,
// logs every accepted game result into a small FIFO for a downstream consumer.
module game_match_tracker #(
  parameter int MATCH_WINS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack,
  input  logic       GAMEOVER,
  input  logic [1:0] WHO,
  input  logic       WINNER,
  input  logic       LOSER,
  output logic [2:0] games_a,
  output logic [2:0] games_b,
  output logic [7:0] pts_a,
  output logic [7:0] pts_b,
  output logic       busy,
  output logic       match_done,
  output logic [1:0] match_who,
  output logic       log_valid,
  output logic [5:0] log_data,
  input  logic       log_ready,
  output logic       overflow,
  output logic       bad_who
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t          r_state, w_next;
  logic            r_go_q;
  logic [2:0]      r_games_a, r_games_b;
  logic [7:0]      r_pts_a, r_pts_b;
  logic [1:0]      r_match_who;
  logic [3:0]      r_idx;
  logic            r_ovf, r_bad;
  logic [5:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;

  logic w_gend, w_acc, w_begin, w_a_win, w_b_win;
  logic w_full, w_pop, w_push;

  assign w_gend  = GAMEOVER & ~r_go_q;
  assign w_acc   = (r_state == S_PLAY) & w_gend;
  assign w_begin = (r_state == S_IDLE) & start;
  assign w_a_win = r_games_a >= 3'(MATCH_WINS);
  assign w_b_win = r_games_b >= 3'(MATCH_WINS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_go_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_go_q  <= GAMEOVER;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PLAY;
      S_PLAY:  if (w_a_win || w_b_win) w_next = S_DONE;
      S_DONE:  if (ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Scores only move in PLAY, which keeps everything frozen through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_games_a   <= '0;
      r_games_b   <= '0;
      r_pts_a     <= '0;
      r_pts_b     <= '0;
      r_match_who <= '0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
    end else if (w_begin) begin
      r_games_a   <= '0;
      r_games_b   <= '0;
      r_pts_a     <= '0;
      r_pts_b     <= '0;
      r_match_who <= '0;
      r_idx       <= '0;
    end else if (r_state == S_PLAY) begin
      if (w_acc && WHO == 2'b10 && r_games_a != 3'd7) r_games_a <= r_games_a + 3'd1;
      if (w_acc && WHO == 2'b01 && r_games_b != 3'd7) r_games_b <= r_games_b + 3'd1;
      if (w_acc && (WHO == 2'b00 || WHO == 2'b11))    r_bad     <= 1'b1;
      if (w_acc)                                      r_idx     <= r_idx + 4'd1;
      if (WINNER && r_pts_a != 8'hff) r_pts_a <= r_pts_a + 8'd1;
      if (LOSER  && r_pts_b != 8'hff) r_pts_b <= r_pts_b + 8'd1;
      if (w_a_win)      r_match_who <= 2'b10;
      else if (w_b_win) r_match_who <= 2'b01;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_pop  = (r_cnt != '0) & log_ready;
  assign w_push = w_acc & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {r_idx, WHO};
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_acc && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign games_a    = r_games_a;
  assign games_b    = r_games_b;
  assign pts_a      = r_pts_a;
  assign pts_b      = r_pts_b;
  assign match_who  = r_match_who;
  assign busy       = r_state == S_PLAY;
  assign match_done = r_state == S_DONE;
  assign log_valid  = r_cnt != '0;
  assign log_data   = r_mem[r_rp];
  assign overflow   = r_ovf;
  assign bad_who    = r_bad;

endmodule

// File: doc/game_match_tracker.md
GAME_MATCH_TRACKER -- requirements
Module: game_match_tracker

Interface
REQ-001 SHALL have parameter MATCH_WINS, default 3, legal 1..7: games one side must win to take the match.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two 2..16: depth of the game-result log FIFO.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a match.
REQ-006 SHALL have port ack, input, 1: acknowledges a finished match.
REQ-007 SHALL have port GAMEOVER, input, 1: game-end flag from the upstream game counter.
REQ-008 SHALL have port WHO, input, 2: game result, 2'b10 = side A (winner side), 2'b01 = side B (loser side); other codes are invalid.
REQ-009 SHALL have port WINNER, input, 1: per-cycle winner-point pulse.
REQ-010 SHALL have port LOSER, input, 1: per-cycle loser-point pulse.
REQ-011 SHALL have port games_a, output, 3: games won by side A in the current match.
REQ-012 SHALL have port games_b, output, 3: games won by side B in the current match.
REQ-013 SHALL have port pts_a, output, 8: WINNER pulses counted in the current match.
REQ-014 SHALL have port pts_b, output, 8: LOSER pulses counted in the current match.
REQ-015 SHALL have port busy, output, 1: high in PLAY.
REQ-016 SHALL have port match_done, output, 1: high in DONE.
REQ-017 SHALL have port match_who, output, 2: match winner, 2'b10 = A, 2'b01 = B, 2'b00 = none.
REQ-018 SHALL have port log_valid, output, 1: FIFO non-empty.
REQ-019 SHALL have port log_data, output, 6: FIFO head, {game_idx[3:0], WHO[1:0]}.
REQ-020 SHALL have port log_ready, input, 1: consumer pops the head when log_valid and log_ready are both high.
REQ-021 SHALL have port overflow, output, 1: sticky flag, a log entry was dropped.
REQ-022 SHALL have port bad_who, output, 1: sticky flag, a game ended with an invalid WHO code.

Function
REQ-023 SHALL implement three states with these transitions: IDLE -> PLAY on start; PLAY -> DONE when games_a or games_b reaches MATCH_WINS; DONE -> IDLE on ack.
REQ-024 SHALL clear games_a, games_b, pts_a, pts_b, match_who and game_idx on the IDLE->PLAY transition.
REQ-025 SHALL ignore start in PLAY and DONE, and ignore ack in IDLE and PLAY.
REQ-026 SHALL register GAMEOVER and detect a game end only on its rising edge (GAMEOVER=1, previous=0), so a GAMEOVER held high counts once.
REQ-027 SHALL act on a game end only in PLAY; game ends in IDLE or DONE are discarded without any counter, log or flag update.
REQ-028 SHALL, on a game end in PLAY with WHO=2'b10, increment games_a in the next cycle; with WHO=2'b01, increment games_b.
REQ-029 SHALL, on a game end with WHO of 2'b00 or 2'b11, set bad_who, leave the scores unchanged, and still push a log entry.
REQ-030 SHALL push {game_idx, WHO} on every game end accepted in PLAY, then increment game_idx (4-bit, wraps 15->0).
REQ-031 SHALL enter DONE in the cycle after the increment that makes a score equal MATCH_WINS, with match_who set to that side in the same cycle.
REQ-032 SHALL hold games_a, games_b, pts_a, pts_b and match_who stable throughout DONE.
REQ-033 SHALL increment pts_a on each cycle WINNER=1 and pts_b on each cycle LOSER=1 while in PLAY, saturating at 255; simultaneous WINNER and LOSER increment both counters.
REQ-034 SHALL implement the FIFO with a registered head, log_data valid whenever log_valid=1, and first-word latency of 1 cycle after the push.
REQ-035 SHALL drop a push and set overflow when the FIFO is full with no pop in the same cycle; push and pop in the same cycle on a full FIFO both succeed.
REQ-036 SHALL hold log_data constant while log_valid=1 and log_ready=0.
REQ-037 SHALL NOT clear the FIFO contents, overflow or bad_who on match start or on ack.

Reset
REQ-038 SHALL, while rst_n=0, asynchronously force state IDLE and drive every counter, pointer and output to 0: games_a, games_b, pts_a, pts_b, match_who, game_idx, the FIFO, log_valid, overflow, bad_who, busy, match_done.
REQ-039 SHALL treat reset asserted mid-match or mid-FIFO-transfer as a full reset, losing all log entries.
REQ-040 SHALL leave IDLE only on a start sampled after rst_n deasserts.

Verification
REQ-041 SHALL be verified by the scenario: start; three GAMEOVER pulses with WHO=10 -> games_a 1,2,3; match_done=1 and match_who=10 the cycle after the third; busy=0.
REQ-042 SHALL be verified by the scenario: GAMEOVER held high 5 cycles with WHO=01 in PLAY -> games_b=1, exactly one log entry {0,01}.
REQ-043 SHALL be verified by the scenario: log_ready=0, five accepted games with FIFO_DEPTH=4 -> four entries idx 0..3 in order, overflow=1; a pop and push in the same cycle while full -> no further drop.
REQ-044 SHALL be verified by the scenario: game end with WHO=11 -> bad_who=1, scores unchanged, entry {idx,11} logged.
REQ-045 SHALL be verified by the scenario: WINNER and LOSER both high for 300 cycles in PLAY -> pts_a=pts_b=255; GAMEOVER in DONE -> no change; ack -> IDLE.
REQ-046 SHALL be verified by the scenario: rst_n low mid-match with games_a=2 and 3 entries logged -> all outputs 0 immediately, log_valid=0.
